cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/sys_defs.sv | 19 +
 rtl/cdb_result_queue.sv | 69 ++++++
 rtl/cdb_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the execute/writeback path: result packet layout
// and default sizing of the common-data-bus arbiter.
package sys_defs;

  localparam int NUM_FU_DEF = 3;
  localparam int QDEPTH_DEF = 2;
  localparam int ROB_TAG_W  = 6;
  localparam int REG_IDX_W  = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                 valid;
    logic                 spec;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [REG_IDX_W-1:0] dest_reg;
    logic [DATA_W-1:0]    value;
  } EX_WR_PACKET;

endpackage

// File: rtl/cdb_result_queue.sv
// Two-entry result queue for one functional unit. Squash filtering, pop and
// enqueue are resolved in one pass so the surviving entries stay in order.
module cdb_result_queue
  import sys_defs::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  EX_WR_PACKET in_pkt,
  input  logic        pop,
  input  logic        squash,
  input  logic        clear_spec,
  output EX_WR_PACKET head,
  output logic        head_ok,
  output logic        full
);

  EX_WR_PACKET ent   [2];
  EX_WR_PACKET ent_n [2];
  logic [1:0]  count;
  logic [1:0]  cnt_n;
  logic        keep0;
  logic        keep1;
  logic        push_ok;

  assign full    = (count == 2'(QDEPTH));
  assign head    = ent[0];
  assign head_ok = keep0;

  // A spec head under squash is never offered to the arbiter this edge.
  always_comb begin
    keep0   = (count != 2'd0) && !(squash && ent[0].spec);
    keep1   = (count == 2'd2) && !(squash && ent[1].spec);
    push_ok = in_pkt.valid && !full && !(squash && in_pkt.spec);
    ent_n[0] = ent[0];
    ent_n[1] = ent[1];
    cnt_n    = 2'd0;
    if (keep0 && !pop) begin
      ent_n[0] = ent[0];
      cnt_n    = 2'd1;
    end
    if (keep1) begin
      ent_n[cnt_n[0]] = ent[1];
      cnt_n           = cnt_n + 2'd1;
    end
    if (push_ok) begin
      ent_n[cnt_n[0]] = in_pkt;
      cnt_n           = cnt_n + 2'd1;
    end
    if (clear_spec && !squash) begin
      ent_n[0].spec = 1'b0;
      ent_n[1].spec = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      count  <= cnt_n;
      ent[0] <= ent_n[0];
      ent[1] <= ent_n[1];
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result queue per functional unit, a
// round-robin grant and a registered broadcast.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  EX_WR_PACKET       fu_packet [NUM_FU],
  output logic [NUM_FU-1:0] fu_stall,
  input  logic              squash,
  input  logic              clear_spec,
  output EX_WR_PACKET       cdb_packet
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  EX_WR_PACKET       head [NUM_FU];
  logic [NUM_FU-1:0] head_ok;
  logic [NUM_FU-1:0] grant_oh;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  rr_next;
  logic [PTR_W:0]    sum;
  logic              grant_any;
  EX_WR_PACKET       cdb_next;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_q
    cdb_result_queue #(.QDEPTH(QDEPTH)) u_q (
      .clock      (clock),
      .reset      (reset),
      .in_pkt     (fu_packet[gi]),
      .pop        (grant_oh[gi]),
      .squash     (squash),
      .clear_spec (clear_spec),
      .head       (head[gi]),
      .head_ok    (head_ok[gi]),
      .full       (fu_stall[gi])
    );
  end

  // Scan upward from rr_ptr with wrap; first eligible queue wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    sum       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
      if (!grant_any && head_ok[sum[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[PTR_W-1:0];
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_next  = (grant_idx == PTR_W'(NUM_FU-1)) ? '0 : grant_idx + PTR_W'(1);
    cdb_next = '0;
    if (grant_any) begin
      cdb_next       = head[grant_idx];
      cdb_next.valid = 1'b1;
      if (clear_spec && !squash) cdb_next.spec = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_packet <= '0;
      rr_ptr     <= '0;
    end else begin
      cdb_packet <= cdb_next;
      if (grant_any) rr_ptr <= rr_next;
    end
  end

endmodule
